taxi_reset_seq: RTL
===================

Name: taxi_reset_seq

Overview:
Reset source and sequencer for the reset network. It generates multi-output active-high resets with a guaranteed minimum assertion width and staged, ordered deassertion. Each output is intended to drive the async-assert reset synchronizer in its destination domain. It sits in the top-level clock/reset block and is gated by a PLL lock indication and a software reset request.

Parameters:
N_OUT, 4, number of reset outputs (>=1); output 0 releases first
PULSE_W, 16, minimum cycles all outputs stay asserted after the last assert cause clears (>=1)
STAGE_GAP, 8, cycles between successive output deassertions (>=1)
CNT_W, $clog2(max(PULSE_W,STAGE_GAP))+1, internal counter width (derived; not overridden)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
lock  input  1  PLL/clock-good, already synchronous to clk; low forces assertion
req  input  1  software reset request, level; high forces assertion
rst_out  output  N_OUT  staged reset outputs, active high, registered
busy  output  1  high while any rst_out bit is high, registered
done  output  1  one-cycle pulse when the final output deasserts, registered

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: rst_out = all ones, busy = 1, done = 0, state = ASSERT, cnt = 0, idx = 0.
- States: ASSERT, RELEASE, IDLE.
- Assert cause: rst | !lock | req. In any state, a cause sampled at an edge moves the state to ASSERT. The same edge sets rst_out to all ones, cnt to 0, idx to 0, busy to 1 and done to 0. This cause has priority over every other transition.
- ASSERT:
  - Each edge with no cause increments cnt.
  - At the edge where cnt == PULSE_W-1, rst_out[0] clears, the state goes to RELEASE, cnt goes to 0 and idx goes to 0.
  - Result: rst_out[0] stays high for exactly PULSE_W edges after the last cause clears.
- RELEASE:
  - Each edge increments cnt.
  - At cnt == STAGE_GAP-1, rst_out[idx+1] clears, idx increments and cnt goes to 0.
  - Outputs release in index order only. No output clears before a lower-index output.
- Final stage: the edge that clears rst_out[N_OUT-1] also moves the state to IDLE, sets done = 1 for that single cycle and sets busy = 0.
- N_OUT = 1: the ASSERT exit edge goes directly to IDLE with done = 1.
- Timing: rst_out[k] falls at edge PULSE_W + k*STAGE_GAP, counted from the first edge with no cause.
- IDLE: all outputs low, cnt held. The block leaves IDLE only on a cause.
- Re-assertion mid-RELEASE: every output goes high again on the next edge, including outputs already released. The full PULSE_W is then re-counted. No partial resume.
- Cause glitches: a single-cycle low on lock or high on req restarts the full sequence.
- Counter rules: cnt saturates at its compare values and never wraps.
- Output hazards: all outputs come directly from flops, so there are no combinational paths to rst_out.

Optional Feature:
Macro: TAXI_RESET_SEQ_ACK_EN
- Defined:
  - Adds input rst_ack, width N_OUT. It carries each destination domain's synchronized reset, returned to clk by a two-flop synchronizer inside this block.
  - In RELEASE, the STAGE_GAP counter for stage idx+1 holds at 0 until the synchronized rst_ack[idx] == 0.
  - done additionally waits for the synchronized rst_ack[N_OUT-1] == 0. busy stays high until then.
  - Assert causes behave unchanged.
- Undefined: the rst_ack port and its synchronizers are absent, and sequencing is purely time-based as above.

Test Plan:
1. Defaults; rst high 3 cycles, lock=1, req=0 -> rst_out = 4'hF through edge 15 after release. Bits 0..3 fall at edges 16, 24, 32 and 40. done high only in the cycle after edge 40; busy falls with it.
2. Defaults; lock low for 1 cycle at edge 28 (bit 0 released, bit 1 released at 24) -> edge 29 shows rst_out = 4'hF. Bit 0 falls 16 edges after lock returns; done does not pulse during the abort.
3. In IDLE, req held high 5 cycles -> rst_out = 4'hF from the next edge. Full 16/8 sequence after req drops; exactly one done pulse.
4. N_OUT=1, PULSE_W=1, STAGE_GAP=1; rst pulse -> rst_out falls on the first edge after release, with done = 1 in the same cycle.
5. rst asserted mid-RELEASE (idx=2) -> all outputs high, busy=1, done=0 next edge. Restart matches scenario 1 timing.
6. ACK_EN defined, defaults; rst_ack[0] held high 20 extra cycles -> rst_out[1] falls 8 edges after the synchronized rst_ack[0] drops, never earlier. done waits for rst_ack[3] low.

Source files
------------

// File: rtl/taxi_reset_seq.sv
// Staged reset sequencer: holds all rst_out high while a cause is present, then releases them in index order.
// Optional macro TAXI_RESET_SEQ_ACK_EN adds rst_ack handshaking so each stage waits for the previous domain.
module taxi_reset_seq #(
  parameter int N_OUT     = 4,
  parameter int PULSE_W   = 16,
  parameter int STAGE_GAP = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lock,
  input  logic             req,
`ifdef TAXI_RESET_SEQ_ACK_EN
  input  logic [N_OUT-1:0] rst_ack,
`endif
  output logic [N_OUT-1:0] rst_out,
  output logic             busy,
  output logic             done
);

  localparam int MAX_W = (PULSE_W > STAGE_GAP) ? PULSE_W : STAGE_GAP;
  localparam int CNT_W = $clog2(MAX_W) + 1;
  localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_OUT - 1);

`ifdef TAXI_RESET_SEQ_ACK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ASSERT,
    RELEASE,
    IDLE
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic [N_OUT-1:0]  rst_out_q;
  logic              busy_q;
  logic              done_q;

  logic              cause_d;
  logic [IDX_W:0]    nxt_idx_d;
  logic              stage_hold_d;
  logic              final_ok_d;

  assign cause_d   = rst | ~lock | req;
  assign nxt_idx_d = {1'b0, idx_q} + (IDX_W+1)'(1);

`ifdef TAXI_RESET_SEQ_ACK_EN
  logic [N_OUT-1:0] ack_s1_q;
  logic [N_OUT-1:0] ack_s2_q;

  // Destinations are presumed in reset until their synchronized ack says otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_s1_q <= '1;
      ack_s2_q <= '1;
    end else begin
      ack_s1_q <= rst_ack;
      ack_s2_q <= ack_s1_q;
    end
  end

  assign stage_hold_d = ack_s2_q[idx_q];
  assign final_ok_d   = ~ack_s2_q[N_OUT-1];
`else
  assign stage_hold_d = 1'b0;
  assign final_ok_d   = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (cause_d) begin
      state_q   <= ASSERT;
      rst_out_q <= '1;
      cnt_q     <= '0;
      idx_q     <= '0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ASSERT: begin
          if (cnt_q == PULSE_LAST) begin
            rst_out_q[0] <= 1'b0;
            cnt_q        <= '0;
            idx_q        <= '0;
            if (N_OUT == 1 && !ACK_EN) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= RELEASE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RELEASE: begin
          // idx at the last output means everything is released and only the final ack is pending.
          if (idx_q == IDX_LAST) begin
            if (final_ok_d) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else if (stage_hold_d) begin
            cnt_q <= '0;
          end else if (cnt_q == GAP_LAST) begin
            rst_out_q <= rst_out_q & ~(N_OUT'(1) << nxt_idx_d);
            idx_q     <= nxt_idx_d[IDX_W-1:0];
            cnt_q     <= '0;
            if (!ACK_EN && (int'(nxt_idx_d) == N_OUT - 1)) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        IDLE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q   <= ASSERT;
          rst_out_q <= '1;
          busy_q    <= 1'b1;
        end
      endcase
    end
  end

  assign rst_out = rst_out_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
